// File: rtl/fsm_arb_pkg.sv
// Shared types and mode constants for the request/grant arbiter.
package fsm_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'b00,
    ARB_GRANT = 2'b01
  } arb_state_t;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

endpackage

// File: rtl/arb_pick.sv
// Combinational priority encoder: lowest set index, or first set index at/after
// rr_ptr (wrapping) when mode selects round robin.
import fsm_arb_pkg::*;

module arb_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] mask,
  input  logic [ID_W-1:0]    rr_ptr,
  input  logic               mode,
  output logic               found,
  output logic [ID_W-1:0]    index
);

  int start;
  int cand;

  // Scan from the farthest candidate back to the start so the last hit wins,
  // leaving the highest-priority requester in index.
  always_comb begin
    found = 1'b0;
    index = '0;
    start = (int'(mode) == ARB_RR) ? int'(rr_ptr) : 0;
    cand  = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = start + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (mask[cand]) begin
        found = 1'b1;
        index = ID_W'(cand);
      end
    end
  end

endmodule

// File: rtl/fsm_arbiter_rr.sv
// N-way request/grant arbiter: fixed or round-robin priority, direct handoff
// between owners, and an optional maximum-hold timeout forcing release.
import fsm_arb_pkg::*;

module fsm_arbiter_rr #(
  parameter int NUM_REQ  = 4,
  parameter int RR_MODE  = 0,
  parameter int MAX_HOLD = 0,
  parameter int ID_W     = $clog2(NUM_REQ)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic [ID_W-1:0]    gnt_id,
  output logic               hold_expired
);

  localparam logic MODE_BIT = (RR_MODE == ARB_RR);
  localparam int   CNT_W    = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? CNT_W'(MAX_HOLD - 1) : '0;

  arb_state_t         state, state_nxt;
  logic [NUM_REQ-1:0] gnt_nxt;
  logic               gnt_valid_nxt;
  logic [ID_W-1:0]    gnt_id_nxt;
  logic               hold_expired_nxt;
  logic [CNT_W-1:0]   hold_cnt, hold_cnt_nxt;
  logic [ID_W-1:0]    rr_ptr, rr_ptr_nxt;

  logic [NUM_REQ-1:0] owner_bit;
  logic [NUM_REQ-1:0] other_req;
  logic               own_req;
  logic               all_found, oth_found;
  logic [ID_W-1:0]    all_idx, oth_idx;
  logic               timeout;
  logic               take;
  logic [ID_W-1:0]    win;

  assign owner_bit = NUM_REQ'(1) << gnt_id;
  assign own_req   = |(req & owner_bit);
  assign other_req = req & ~owner_bit;

  arb_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick_all (
    .mask   (req),
    .rr_ptr (rr_ptr),
    .mode   (MODE_BIT),
    .found  (all_found),
    .index  (all_idx)
  );

  arb_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick_oth (
    .mask   (other_req),
    .rr_ptr (rr_ptr),
    .mode   (MODE_BIT),
    .found  (oth_found),
    .index  (oth_idx)
  );

  // Saturated counter still satisfies >=, so a late competitor is served at once.
  assign timeout = (MAX_HOLD != 0) && (hold_cnt >= HOLD_LAST) && oth_found && own_req;

  always_comb begin
    state_nxt        = state;
    gnt_nxt          = gnt;
    gnt_valid_nxt    = gnt_valid;
    gnt_id_nxt       = gnt_id;
    hold_expired_nxt = 1'b0;
    hold_cnt_nxt     = hold_cnt;
    rr_ptr_nxt       = rr_ptr;
    take             = 1'b0;
    win              = '0;

    case (state)
      ARB_IDLE: begin
        if (all_found) begin
          take = 1'b1;
          win  = all_idx;
        end else begin
          gnt_nxt       = '0;
          gnt_valid_nxt = 1'b0;
          gnt_id_nxt    = '0;
          hold_cnt_nxt  = '0;
        end
      end
      ARB_GRANT: begin
        if (!own_req) begin
          if (all_found) begin
            take = 1'b1;
            win  = all_idx;
          end else begin
            state_nxt     = ARB_IDLE;
            gnt_nxt       = '0;
            gnt_valid_nxt = 1'b0;
            gnt_id_nxt    = '0;
            hold_cnt_nxt  = '0;
          end
        end else if (timeout) begin
          take             = 1'b1;
          win              = oth_idx;
          hold_expired_nxt = 1'b1;
        end else if (hold_cnt < HOLD_MAX) begin
          hold_cnt_nxt = hold_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt     = ARB_IDLE;
        gnt_nxt       = '0;
        gnt_valid_nxt = 1'b0;
        gnt_id_nxt    = '0;
        hold_cnt_nxt  = '0;
      end
    endcase

    if (take) begin
      state_nxt     = ARB_GRANT;
      gnt_nxt       = NUM_REQ'(1) << win;
      gnt_valid_nxt = 1'b1;
      gnt_id_nxt    = win;
      hold_cnt_nxt  = '0;
      if (MODE_BIT) rr_ptr_nxt = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
      else          rr_ptr_nxt = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ARB_IDLE;
      gnt          <= '0;
      gnt_valid    <= 1'b0;
      gnt_id       <= '0;
      hold_expired <= 1'b0;
      hold_cnt     <= '0;
      rr_ptr       <= '0;
    end else begin
      state        <= state_nxt;
      gnt          <= gnt_nxt;
      gnt_valid    <= gnt_valid_nxt;
      gnt_id       <= gnt_id_nxt;
      hold_expired <= hold_expired_nxt;
      hold_cnt     <= hold_cnt_nxt;
      rr_ptr       <= rr_ptr_nxt;
    end
  end

endmodule

// File: tb/tb_fsm_arbiter_rr.sv
// Bench for fsm_arbiter_rr: three instances (fixed, round robin, round robin with
// MAX_HOLD=3) driven by vector tables, directed sequences and random traffic.
module tb_fsm_arbiter_rr;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [3:0] req          [3];
  logic [3:0] gnt          [3];
  logic       gnt_valid    [3];
  logic [1:0] gnt_id       [3];
  logic       hold_expired [3];

  int applied     = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  fsm_arbiter_rr #(.NUM_REQ(4), .RR_MODE(0), .MAX_HOLD(0)) u_fix (
    .clock(clock), .reset_n(reset_n), .req(req[0]), .gnt(gnt[0]),
    .gnt_valid(gnt_valid[0]), .gnt_id(gnt_id[0]), .hold_expired(hold_expired[0])
  );

  fsm_arbiter_rr #(.NUM_REQ(4), .RR_MODE(1), .MAX_HOLD(0)) u_rr (
    .clock(clock), .reset_n(reset_n), .req(req[1]), .gnt(gnt[1]),
    .gnt_valid(gnt_valid[1]), .gnt_id(gnt_id[1]), .hold_expired(hold_expired[1])
  );

  fsm_arbiter_rr #(.NUM_REQ(4), .RR_MODE(1), .MAX_HOLD(3)) u_to (
    .clock(clock), .reset_n(reset_n), .req(req[2]), .gnt(gnt[2]),
    .gnt_valid(gnt_valid[2]), .gnt_id(gnt_id[2]), .hold_expired(hold_expired[2])
  );

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       valid;
  } vec_t;

  // owner = -1 when idle; held = cycles the current owner has seen its grant
  typedef struct {
    int owner;
    int held;
    int ptr;
    bit expired;
  } mdl_t;

  vec_t tbl [13];
  mdl_t mdl [3];

  function automatic bit rr_of(int d);
    return d != 0;
  endfunction

  function automatic int mh_of(int d);
    return (d == 2) ? 3 : 0;
  endfunction

  function automatic int ref_pick(logic [3:0] mask, int ptr, bit rr);
    for (int k = 0; k < 4; k++) begin
      int c;
      c = rr ? (ptr + k) % 4 : k;
      if (mask[c]) return c;
    end
    return -1;
  endfunction

  function automatic mdl_t ref_next(mdl_t m, logic [3:0] r, bit rr, int mh);
    mdl_t       n;
    logic [3:0] others;
    int         w;
    n = m;
    n.expired = 1'b0;
    w = -1;
    if (m.owner < 0 || !r[m.owner]) begin
      w = ref_pick(r, m.ptr, rr);
    end else begin
      others = r;
      others[m.owner] = 1'b0;
      if (mh > 0 && m.held >= mh && others != 4'b0000) begin
        w = ref_pick(others, m.ptr, rr);
        n.expired = 1'b1;
      end else begin
        n.held = m.held + 1;
        return n;
      end
    end
    if (w < 0) begin
      n.owner = -1;
      n.held  = 0;
    end else begin
      n.owner = w;
      n.held  = 1;
      n.ptr   = rr ? (w + 1) % 4 : 0;
    end
    return n;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_stimulus(int d, logic [3:0] r);
    req[d] = r;
  endtask

  task automatic check_output(string name, logic [31:0] act, logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_dut(int d, string tag, logic [3:0] eg, logic [1:0] eid,
                           logic ev, logic eexp);
    check_output($sformatf("d%0d %s gnt", d, tag), 32'(gnt[d]), 32'(eg));
    check_output($sformatf("d%0d %s gnt_id", d, tag), 32'(gnt_id[d]), 32'(eid));
    check_output($sformatf("d%0d %s gnt_valid", d, tag), 32'(gnt_valid[d]), 32'(ev));
    check_output($sformatf("d%0d %s hold_expired", d, tag), 32'(hold_expired[d]), 32'(eexp));
  endtask

  task automatic check_model(int d, string tag);
    logic [3:0] eg;
    logic [1:0] eid;
    eg  = (mdl[d].owner < 0) ? 4'b0000 : 4'(4'b0001 << mdl[d].owner);
    eid = (mdl[d].owner < 0) ? 2'd0 : 2'(mdl[d].owner);
    check_dut(d, tag, eg, eid, mdl[d].owner >= 0, mdl[d].expired);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: run still active at 500000, expected $finish earlier");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] e;
    logic [3:0] r;

    tbl[0]  = '{4'b1010, 4'b0010, 2'd1, 1'b1};
    tbl[1]  = '{4'b1010, 4'b0010, 2'd1, 1'b1};
    tbl[2]  = '{4'b1000, 4'b1000, 2'd3, 1'b1};
    tbl[3]  = '{4'b1001, 4'b1000, 2'd3, 1'b1};
    tbl[4]  = '{4'b0001, 4'b0001, 2'd0, 1'b1};
    tbl[5]  = '{4'b0000, 4'b0000, 2'd0, 1'b0};
    tbl[6]  = '{4'b0000, 4'b0000, 2'd0, 1'b0};
    tbl[7]  = '{4'b0100, 4'b0100, 2'd2, 1'b1};
    tbl[8]  = '{4'b0110, 4'b0100, 2'd2, 1'b1};
    tbl[9]  = '{4'b0010, 4'b0010, 2'd1, 1'b1};
    tbl[10] = '{4'b1111, 4'b0010, 2'd1, 1'b1};
    tbl[11] = '{4'b1101, 4'b0001, 2'd0, 1'b1};
    tbl[12] = '{4'b0000, 4'b0000, 2'd0, 1'b0};

    reset_n = 1'b0;
    for (int d = 0; d < 3; d++) apply_stimulus(d, 4'b0000);
    tick();
    tick();
    for (int d = 0; d < 3; d++) check_dut(d, "reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    reset_n = 1'b1;

    // Fixed priority: 1-cycle latency, direct handoff, release to idle
    for (int i = 0; i < 13; i++) begin
      apply_stimulus(0, tbl[i].req);
      tick();
      check_dut(0, $sformatf("tbl%0d", i), tbl[i].gnt, tbl[i].id, tbl[i].valid, 1'b0);
    end

    // Round robin: owners drop in turn, order 0,1,2,3,0
    apply_stimulus(1, 4'b1111);
    tick();
    check_dut(1, "rr_first", 4'b0001, 2'd0, 1'b1, 1'b0);
    tick();
    check_dut(1, "rr_hold0", 4'b0001, 2'd0, 1'b1, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      apply_stimulus(1, 4'b1111 & ~(4'b0001 << ((k - 1) % 4)));
      tick();
      e = 4'b0001 << (k % 4);
      check_dut(1, $sformatf("rr_turn%0d", k), e, 2'(k % 4), 1'b1, 1'b0);
      apply_stimulus(1, 4'b1111);
      tick();
      check_dut(1, $sformatf("rr_keep%0d", k), e, 2'(k % 4), 1'b1, 1'b0);
    end

    // Timeout with a waiting competitor
    apply_stimulus(2, 4'b0001);
    tick();
    check_dut(2, "to_c1", 4'b0001, 2'd0, 1'b1, 1'b0);
    apply_stimulus(2, 4'b0101);
    tick();
    check_dut(2, "to_c2", 4'b0001, 2'd0, 1'b1, 1'b0);
    tick();
    check_dut(2, "to_c3", 4'b0001, 2'd0, 1'b1, 1'b0);
    tick();
    check_dut(2, "to_fire", 4'b0100, 2'd2, 1'b1, 1'b1);
    tick();
    check_dut(2, "to_after", 4'b0100, 2'd2, 1'b1, 1'b0);
    apply_stimulus(2, 4'b0000);
    tick();
    check_dut(2, "to_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Timeout armed but no competitor: owner keeps it, then late competitor wins
    apply_stimulus(2, 4'b0001);
    tick();
    check_dut(2, "solo_grant", 4'b0001, 2'd0, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) begin
      tick();
      check_dut(2, $sformatf("solo%0d", k), 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    apply_stimulus(2, 4'b0011);
    tick();
    check_dut(2, "late_comp", 4'b0010, 2'd1, 1'b1, 1'b1);
    tick();
    check_dut(2, "late_hold", 4'b0010, 2'd1, 1'b1, 1'b0);

    // Asynchronous reset during a grant; pointer must restart at 0
    apply_stimulus(1, 4'b0100);
    tick();
    check_dut(1, "pre_rst", 4'b0100, 2'd2, 1'b1, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) check_dut(d, "async_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
    apply_stimulus(1, 4'b1001);
    tick();
    reset_n = 1'b1;
    tick();
    check_dut(1, "post_rst", 4'b0001, 2'd0, 1'b1, 1'b0);
    apply_stimulus(1, 4'b1000);
    tick();
    check_dut(1, "post_rst2", 4'b1000, 2'd3, 1'b1, 1'b0);

    // Random traffic against the reference model
    reset_n = 1'b0;
    for (int d = 0; d < 3; d++) apply_stimulus(d, 4'b0000);
    tick();
    reset_n = 1'b1;
    for (int d = 0; d < 3; d++) mdl[d] = '{-1, 0, 0, 1'b0};
    for (int cyc = 0; cyc < 300; cyc++) begin
      for (int d = 0; d < 3; d++) begin
        r = req[d];
        if ($urandom_range(0, 2) == 0) r = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 9) == 0) r = 4'b0000;
        apply_stimulus(d, r);
        mdl[d] = ref_next(mdl[d], r, rr_of(d), mh_of(d));
      end
      tick();
      for (int d = 0; d < 3; d++) check_model(d, $sformatf("rand%0d", cyc));
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
